// File: rtl/simple_proc_datapath.sv
// Datapath of the multi-cycle simple processor: PC, instruction latch, register
// file, A/G registers, add/subtract ALU, shared bus and display register.
module simple_proc_datapath #(
   parameter int W   = 8,
   parameter int PCW = 8
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [8:0]     instr_in,
   input  logic [W-1:0]   ext_data,
   input  logic           _Extern,
   input  logic           Gout,
   input  logic           Iout,
   input  logic           RdX,
   input  logic           RdY,
   input  logic           Ain,
   input  logic           Gin,
   input  logic           WrX,
   input  logic           DPin,
   input  logic           add_sub,
   input  logic           pc_en,
   input  logic           ILin,
   output logic [PCW-1:0] pc,
   output logic [2:0]     operation,
   output logic [W-1:0]   disp,
   output logic [W-1:0]   bus
);

   localparam int NREG = 8;
   localparam logic [PCW-1:0] PC_STEP = PCW'(1);

   logic [PCW-1:0] pc_q, pc_d;
   logic [8:0]     ir_q, ir_d;
   logic [W-1:0]   rf_q [NREG];
   logic [W-1:0]   rf_d [NREG];
   logic [W-1:0]   a_q, a_d;
   logic [W-1:0]   g_q, g_d;
   logic [W-1:0]   disp_q, disp_d;

   logic [2:0]     x_s;
   logic [2:0]     y_s;
   logic [W-1:0]   imm_s;
   logic [W-1:0]   bus_s;
   logic [W-1:0]   alu_s;

   assign x_s   = ir_q[5:3];
   assign y_s   = ir_q[2:0];
   assign imm_s = {{(W-3){1'b0}}, ir_q[2:0]};

   // Bus source mux; fixed priority defines the result when selects overlap.
   always_comb begin
      bus_s = {W{1'b0}};
      if (_Extern) begin
         bus_s = ext_data;
      end else if (Gout) begin
         bus_s = g_q;
      end else if (Iout) begin
         bus_s = imm_s;
      end else if (RdX) begin
         bus_s = rf_q[x_s];
      end else if (RdY) begin
         bus_s = rf_q[y_s];
      end else begin
         bus_s = {W{1'b0}};
      end
   end

   // ALU: A op bus, modulo 2^W with carry/borrow dropped.
   always_comb begin
      alu_s = {W{1'b0}};
      if (add_sub) begin
         alu_s = a_q - bus_s;
      end else begin
         alu_s = a_q + bus_s;
      end
   end

   // Next-state for PC, IR and the operand/result/display registers.
   always_comb begin
      pc_d   = pc_q;
      ir_d   = ir_q;
      a_d    = a_q;
      g_d    = g_q;
      disp_d = disp_q;
      if (pc_en) begin
         pc_d = pc_q + PC_STEP;
      end else begin
         pc_d = pc_q;
      end
      if (ILin) begin
         ir_d = instr_in;
      end else begin
         ir_d = ir_q;
      end
      // G samples the pre-edge A, so Ain and Gin together behave as a pipeline.
      if (Ain) begin
         a_d = bus_s;
      end else begin
         a_d = a_q;
      end
      if (Gin) begin
         g_d = alu_s;
      end else begin
         g_d = g_q;
      end
      if (DPin) begin
         disp_d = bus_s;
      end else begin
         disp_d = disp_q;
      end
   end

   // Register file write port; the bus carries the old R[X] on a same-cycle read.
   always_comb begin
      for (int i = 0; i < NREG; i++) begin
         if (WrX && (x_s == 3'(i))) begin
            rf_d[i] = bus_s;
         end else begin
            rf_d[i] = rf_q[i];
         end
      end
   end

   // State registers with asynchronous clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q   <= {PCW{1'b0}};
         ir_q   <= 9'b0_0000_0000;
         a_q    <= {W{1'b0}};
         g_q    <= {W{1'b0}};
         disp_q <= {W{1'b0}};
         for (int i = 0; i < NREG; i++) begin
            rf_q[i] <= {W{1'b0}};
         end
      end else begin
         pc_q   <= pc_d;
         ir_q   <= ir_d;
         a_q    <= a_d;
         g_q    <= g_d;
         disp_q <= disp_d;
         for (int i = 0; i < NREG; i++) begin
            rf_q[i] <= rf_d[i];
         end
      end
   end

   assign pc        = pc_q;
   assign operation = ir_q[8:6];
   assign disp      = disp_q;
   assign bus       = bus_s;

endmodule

// File: tb/tb_simple_proc_datapath.sv
// Directed bench for simple_proc_datapath: drives the control sequences the
// state machine would issue and checks results against hand-computed values.
module tb_simple_proc_datapath;

   localparam int W   = 8;
   localparam int PCW = 8;

   logic           clk = 1'b0;
   logic           reset;
   logic [8:0]     instr_in;
   logic [W-1:0]   ext_data;
   logic           _Extern, Gout, Iout, RdX, RdY;
   logic           Ain, Gin, WrX, DPin, add_sub, pc_en, ILin;
   logic [PCW-1:0] pc;
   logic [2:0]     operation;
   logic [W-1:0]   disp;
   logic [W-1:0]   bus;

   int pass_cnt  = 0;
   int total_cnt = 0;

   simple_proc_datapath #(.W(W), .PCW(PCW)) dut (
      .clk(clk), .reset(reset), .instr_in(instr_in), .ext_data(ext_data),
      ._Extern(_Extern), .Gout(Gout), .Iout(Iout), .RdX(RdX), .RdY(RdY),
      .Ain(Ain), .Gin(Gin), .WrX(WrX), .DPin(DPin), .add_sub(add_sub),
      .pc_en(pc_en), .ILin(ILin), .pc(pc), .operation(operation),
      .disp(disp), .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_ctl();
      _Extern = 1'b0; Gout = 1'b0; Iout = 1'b0; RdX = 1'b0; RdY = 1'b0;
      Ain = 1'b0; Gin = 1'b0; WrX = 1'b0; DPin = 1'b0; add_sub = 1'b0;
      pc_en = 1'b0; ILin = 1'b0;
   endtask

   task automatic fetch(input logic [8:0] instr, input logic adv);
      clear_ctl();
      instr_in = instr; ILin = 1'b1; pc_en = adv;
      step();
      clear_ctl();
   endtask

   task automatic load_reg(input logic [2:0] x, input logic [7:0] v);
      fetch({3'b000, x, 3'b000}, 1'b0);
      _Extern = 1'b1; WrX = 1'b1; ext_data = v;
      step();
      clear_ctl();
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      #1;
      reset = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      logic [7:0] v;
      total_cnt++; if (pc !== 8'h00) $display("FAIL por_pc: got %h want 00", pc); else pass_cnt++;
      total_cnt++; if (bus !== 8'h00) $display("FAIL por_bus: got %h want 00", bus); else pass_cnt++;
      reset = 1'b0;
      for (int i = 0; i < 8; i++) begin
         v = 8'h11 * 8'(i + 1);
         load_reg(3'(i), v);
      end
      fetch({3'b110, 3'd7, 3'b000}, 1'b1);
      RdX = 1'b1; DPin = 1'b1;
      step();
      clear_ctl();
      total_cnt++; if (disp !== 8'h88) $display("FAIL pre_reset_disp: got %h want 88", disp); else pass_cnt++;
      pulse_reset();
      total_cnt++; if (pc !== 8'h00) $display("FAIL reset_pc: got %h want 00", pc); else pass_cnt++;
      total_cnt++; if (operation !== 3'b000) $display("FAIL reset_op: got %b want 000", operation); else pass_cnt++;
      total_cnt++; if (disp !== 8'h00) $display("FAIL reset_disp: got %h want 00", disp); else pass_cnt++;
      total_cnt++; if (bus !== 8'h00) $display("FAIL reset_bus: got %h want 00", bus); else pass_cnt++;
      for (int i = 0; i < 8; i++) begin
         fetch({3'b110, 3'(i), 3'b000}, 1'b0);
         RdX = 1'b1;
         #1;
         total_cnt++; if (bus !== 8'h00) $display("FAIL reset_R%0d_bus: got %h want 00", i, bus); else pass_cnt++;
         DPin = 1'b1;
         step();
         clear_ctl();
         total_cnt++; if (disp !== 8'h00) $display("FAIL reset_R%0d_disp: got %h want 00", i, disp); else pass_cnt++;
      end
   endtask

   task automatic test_load();
      pulse_reset();
      fetch(9'b000_011_000, 1'b1);
      _Extern = 1'b1; WrX = 1'b1; ext_data = 8'h2A;
      #1;
      total_cnt++; if (bus !== 8'h2A) $display("FAIL load_bus: got %h want 2a", bus); else pass_cnt++;
      step();
      clear_ctl();
      total_cnt++; if (pc !== 8'h01) $display("FAIL load_pc: got %h want 01", pc); else pass_cnt++;
      total_cnt++; if (operation !== 3'b000) $display("FAIL load_op: got %b want 000", operation); else pass_cnt++;
      RdX = 1'b1;
      #1;
      total_cnt++; if (bus !== 8'h2A) $display("FAIL load_R3: got %h want 2a", bus); else pass_cnt++;
      clear_ctl();
   endtask

   task automatic test_add();
      load_reg(3'd1, 8'h05);
      load_reg(3'd2, 8'h07);
      fetch({3'b001, 3'd1, 3'd2}, 1'b1);
      total_cnt++; if (operation !== 3'b001) $display("FAIL add_op: got %b want 001", operation); else pass_cnt++;
      RdY = 1'b1; Ain = 1'b1; step(); clear_ctl();
      RdX = 1'b1; Gin = 1'b1; step(); clear_ctl();
      Gout = 1'b1; WrX = 1'b1;
      #1;
      total_cnt++; if (bus !== 8'h0C) $display("FAIL add_bus_write_x: got %h want 0c", bus); else pass_cnt++;
      step(); clear_ctl();
      RdX = 1'b1;
      #1;
      total_cnt++; if (bus !== 8'h0C) $display("FAIL add_R1: got %h want 0c", bus); else pass_cnt++;
      clear_ctl();
   endtask

   task automatic test_sub();
      load_reg(3'd1, 8'h03);
      load_reg(3'd2, 8'h05);
      fetch({3'b010, 3'd1, 3'd2}, 1'b1);
      RdX = 1'b1; Ain = 1'b1; step(); clear_ctl();
      RdY = 1'b1; Gin = 1'b1; add_sub = 1'b1; step(); clear_ctl();
      Gout = 1'b1; WrX = 1'b1; step(); clear_ctl();
      RdX = 1'b1;
      #1;
      total_cnt++; if (bus !== 8'hFE) $display("FAIL sub_R1: got %h want fe", bus); else pass_cnt++;
      fetch({3'b101, 3'd1, 3'd3}, 1'b1);
      RdX = 1'b1; Ain = 1'b1; step(); clear_ctl();
      Iout = 1'b1; Gin = 1'b1; add_sub = 1'b1; step(); clear_ctl();
      Gout = 1'b1; WrX = 1'b1; step(); clear_ctl();
      RdX = 1'b1;
      #1;
      total_cnt++; if (bus !== 8'hFB) $display("FAIL subi_R1: got %h want fb", bus); else pass_cnt++;
      clear_ctl();
   endtask

   task automatic test_addi_disp();
      load_reg(3'd4, 8'hFF);
      fetch({3'b110, 3'd4, 3'd0}, 1'b1);
      RdX = 1'b1; DPin = 1'b1; step(); clear_ctl();
      total_cnt++; if (disp !== 8'hFF) $display("FAIL disp_ff: got %h want ff", disp); else pass_cnt++;
      fetch({3'b100, 3'd4, 3'd1}, 1'b1);
      RdX = 1'b1; Ain = 1'b1; step(); clear_ctl();
      Iout = 1'b1; Gin = 1'b1; step(); clear_ctl();
      Gout = 1'b1; WrX = 1'b1; step(); clear_ctl();
      RdX = 1'b1;
      #1;
      total_cnt++; if (bus !== 8'h00) $display("FAIL addi_R4: got %h want 00", bus); else pass_cnt++;
      fetch({3'b110, 3'd4, 3'd0}, 1'b1);
      RdX = 1'b1; DPin = 1'b1; step(); clear_ctl();
      total_cnt++; if (disp !== 8'h00) $display("FAIL disp_zero: got %h want 00", disp); else pass_cnt++;
   endtask

   task automatic test_mv();
      load_reg(3'd5, 8'h33);
      load_reg(3'd6, 8'h99);
      fetch({3'b011, 3'd5, 3'd6}, 1'b1);
      RdY = 1'b1; Ain = 1'b1; step(); clear_ctl();
      Gin = 1'b1; step(); clear_ctl();
      Gout = 1'b1; WrX = 1'b1; step(); clear_ctl();
      RdX = 1'b1;
      #1;
      total_cnt++; if (bus !== 8'h99) $display("FAIL mv_R5: got %h want 99", bus); else pass_cnt++;
      clear_ctl();
   endtask

   task automatic test_priority();
      load_reg(3'd2, 8'hA2);
      load_reg(3'd5, 8'hB5);
      _Extern = 1'b1; ext_data = 8'h30; Ain = 1'b1; step(); clear_ctl();
      Gin = 1'b1; step(); clear_ctl();
      fetch({3'b111, 3'd2, 3'd5}, 1'b0);
      total_cnt++; if (operation !== 3'b111) $display("FAIL prio_op: got %b want 111", operation); else pass_cnt++;
      ext_data = 8'hE7;
      _Extern = 1'b1; Gout = 1'b1; Iout = 1'b1; RdX = 1'b1; RdY = 1'b1;
      #1;
      total_cnt++; if (bus !== 8'hE7) $display("FAIL prio_ext: got %h want e7", bus); else pass_cnt++;
      _Extern = 1'b0; #1;
      total_cnt++; if (bus !== 8'h30) $display("FAIL prio_g: got %h want 30", bus); else pass_cnt++;
      Gout = 1'b0; #1;
      total_cnt++; if (bus !== 8'h05) $display("FAIL prio_imm: got %h want 05", bus); else pass_cnt++;
      Iout = 1'b0; #1;
      total_cnt++; if (bus !== 8'hA2) $display("FAIL prio_rdx: got %h want a2", bus); else pass_cnt++;
      RdX = 1'b0; #1;
      total_cnt++; if (bus !== 8'hB5) $display("FAIL prio_rdy: got %h want b5", bus); else pass_cnt++;
      RdY = 1'b0; #1;
      total_cnt++; if (bus !== 8'h00) $display("FAIL prio_none: got %h want 00", bus); else pass_cnt++;
      clear_ctl();
   endtask

   task automatic test_ain_gin();
      _Extern = 1'b1; ext_data = 8'h10; Ain = 1'b1; step(); clear_ctl();
      _Extern = 1'b1; ext_data = 8'h03; Ain = 1'b1; Gin = 1'b1; step(); clear_ctl();
      Gout = 1'b1;
      #1;
      total_cnt++; if (bus !== 8'h13) $display("FAIL ain_gin_g: got %h want 13", bus); else pass_cnt++;
      clear_ctl();
      Gin = 1'b1; add_sub = 1'b1; step(); clear_ctl();
      Gout = 1'b1;
      #1;
      total_cnt++; if (bus !== 8'h03) $display("FAIL gin_nosel: got %h want 03", bus); else pass_cnt++;
      clear_ctl();
   endtask

   task automatic test_pc_wrap();
      pulse_reset();
      pc_en = 1'b1;
      repeat (255) step();
      total_cnt++; if (pc !== 8'hFF) $display("FAIL pc_255: got %h want ff", pc); else pass_cnt++;
      step();
      total_cnt++; if (pc !== 8'h00) $display("FAIL pc_wrap: got %h want 00", pc); else pass_cnt++;
      clear_ctl();
   endtask

   task automatic test_async_reset();
      fetch({3'b001, 3'd7, 3'd0}, 1'b1);
      _Extern = 1'b1; ext_data = 8'h40; Ain = 1'b1; step(); clear_ctl();
      _Extern = 1'b1; ext_data = 8'h01; Gin = 1'b1; step(); clear_ctl();
      Gout = 1'b1; DPin = 1'b1; step(); clear_ctl();
      Gout = 1'b1; WrX = 1'b1;
      #1;
      total_cnt++; if (bus !== 8'h41) $display("FAIL ar_pre_bus: got %h want 41", bus); else pass_cnt++;
      #2;
      reset = 1'b1;
      #1;
      total_cnt++; if (pc !== 8'h00) $display("FAIL ar_pc: got %h want 00", pc); else pass_cnt++;
      total_cnt++; if (operation !== 3'b000) $display("FAIL ar_op: got %b want 000", operation); else pass_cnt++;
      total_cnt++; if (disp !== 8'h00) $display("FAIL ar_disp: got %h want 00", disp); else pass_cnt++;
      total_cnt++; if (bus !== 8'h00) $display("FAIL ar_bus: got %h want 00", bus); else pass_cnt++;
      clear_ctl();
      step();
      reset = 1'b0;
      fetch({3'b000, 3'd7, 3'd0}, 1'b1);
      total_cnt++; if (pc !== 8'h01) $display("FAIL ar_resume_pc: got %h want 01", pc); else pass_cnt++;
      RdX = 1'b1;
      #1;
      total_cnt++; if (bus !== 8'h00) $display("FAIL ar_R7: got %h want 00", bus); else pass_cnt++;
      clear_ctl();
   endtask

   initial begin
      reset = 1'b1;
      instr_in = 9'b0_0000_0000;
      ext_data = 8'h00;
      clear_ctl();
      #12;
      test_reset();
      test_load();
      test_add();
      test_sub();
      test_addi_disp();
      test_mv();
      test_priority();
      test_ain_gin();
      test_pc_wrap();
      test_async_reset();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/simple_proc_datapath.md
# simple_proc_datapath

- Datapath for the multi-cycle simple processor, driven directly by the control state machine.
- Holds the following state:
  - program counter and instruction latch;
  - 8-entry register file;
  - A operand register and G result register;
  - add/subtract ALU;
  - shared internal bus;
  - display register.
- Returns the latched opcode to the control state machine.
- Consumes the control signals the state machine asserts in each state.

## Interface
Parameters:
- W, 8, data width of registers, bus, ALU, ext_data and disp.
- PCW, 8, program counter width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high.
- instr_in  input  9  instruction word from instruction memory at address pc (combinational memory outside this block). Fields: [8:6] opcode, [5:3] X, [2:0] Y/imm.
- ext_data  input  W  external load data.
- _Extern, Gout, Iout, RdX, RdY  input  1 each  bus source selects.
- Ain, Gin, WrX, DPin  input  1 each  register load enables.
- add_sub  input  1  ALU operation: 0 add, 1 subtract.
- pc_en  input  1  PC increment enable.
- ILin  input  1  instruction latch enable.
- pc  output  PCW  current program counter.
- operation  output  3  opcode field of the latched instruction (IR[8:6]).
- disp  output  W  display register.
- bus  output  W  current bus value, for debug and verification.

## Operation
- Instruction register IR (9 bits): IR <= instr_in when ILin=1.
- Program counter: pc <= pc+1 when pc_en=1; wraps modulo 2^PCW.
- X = IR[5:3], Y = IR[2:0]. imm = {W-3 zeros, IR[2:0]}.
- Bus mux is purely combinational, fixed priority:
  - _Extern → ext_data
  - else Gout → G
  - else Iout → imm
  - else RdX → R[X]
  - else RdY → R[Y]
  - else 0
- Normal control keeps the selects one-hot; the priority order defines behaviour when they are not.
- Register file R0..R7, W bits each: R[X] <= bus when WrX=1. No hardwired registers.
- A <= bus when Ain=1.
- G <= A + bus (add_sub=0) or A - bus (add_sub=1) when Gin=1.
- ALU arithmetic is modulo 2^W; carry and borrow are discarded.
- disp <= bus when DPin=1.
- Resulting instruction semantics under the state machine:

| Instruction | States and transfers | Result |
|---|---|---|
| load | LOAD: R[X] <= ext_data | R[X] = ext_data |
| add | READ_Y: A <= R[Y]; ADD: G <= A + R[X]; WRITE_X: R[X] <= G | R[X] = R[Y] + R[X] |
| sub | READ_X: A <= R[X]; SUB: G <= A - R[Y] | R[X] = R[X] - R[Y] |
| mv | bus = 0 in the MV state, so G <= A | R[X] = R[Y] |
| addi | READ_X, then ADDI | R[X] = R[X] + imm |
| subi | READ_X, then SUBI | R[X] = R[X] - imm |
| disp | DISP: disp <= R[X] | disp = R[X] |
| halt | no datapath activity | no change |

- Reset: pc, IR, R0..R7, A, G and disp all clear to 0. Hence operation=0 and bus=0 (no selects asserted).

## Timing
- Single clock domain; every register updates on the rising edge in which its enable is high.
- Latencies through the instruction sequence:
  - FETCH edge: IR captures the instruction; pc advances.
  - operation is valid from that edge, i.e. throughout DECODE.
  - An instruction completes at the edge ending LOAD, WRITE_X or DISP.
- Simultaneous write and read of the same register: the bus shows the old R[X], and the write lands at the edge. There is no bypass.
- Ain and Gin in the same cycle: G uses the old A; A captures the bus.
- Gin with no select asserted: G <= A ± 0.
- Reset asserted mid-instruction: all state clears immediately and asynchronously, without waiting for clk. Operation resumes from pc=0 on the first edge after reset deasserts.
- X or Y field equal to 7: fully valid; no out-of-range case exists.

## Test plan
- Reset with arbitrary prior state → pc=0, operation=0, disp=0, bus=0, all registers 0 (check by DPin+RdX sweep over X=0..7).
- ILin=1, pc_en=1, instr_in=9'b000_011_000, then _Extern=1 + WrX=1 with ext_data=8'h2A → pc=1, operation=000, R3=8'h2A.
- R1=5, R2=7, X=1, Y=2, drive the READ_Y, ADD, WRITE_X control sequence → R1=12, bus=12 during WRITE_X.
- R1=3, R2=5, drive the sub control sequence (X=1, Y=2) → R1=8'hFE (wrap). Then subi with imm=3 → R1=8'hFB.
- R4=8'hFF, drive the addi sequence with imm=1 (X=4) → R4=0. Then disp of X=4 → disp=0.
- pc_en held 256 cycles from pc=0 → pc returns to 0. Assert reset asynchronously mid-WRITE_X with WrX=1 → register unchanged from 0, and all outputs are 0 before the next clk edge.
